// File: rtl/ram_burst_pkg.sv
// Shared types and constants for the RAM burst master and its read buffer.
package ram_burst_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_WRITE = 2'd1;
  localparam state_t ST_READ  = 2'd2;
  localparam state_t ST_DRAIN = 2'd3;

  localparam int RDBUF_DEPTH = 2;

endpackage

// File: rtl/ram_burst_rdbuf.sv
// Two-entry synchronous FIFO that catches RAM read data; zero-latency valid/ready pop side.
// Push is unconditional from the caller's point of view: the master never issues more reads than free slots.
module ram_burst_rdbuf
  import ram_burst_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_vld_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_rdy_i,
  output logic             pop_vld_o,
  output logic [WIDTH-1:0] pop_dat_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] mem_q [RDBUF_DEPTH];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic             push;
  logic             pop;

  assign pop_vld_o = (count_q != 2'd0);
  assign pop_dat_o = pop_vld_o ? mem_q[rd_ptr_q] : '0;
  assign count_o   = count_q;
  assign push      = push_vld_i && (count_q != 2'(RDBUF_DEPTH));
  assign pop       = pop_vld_o && pop_rdy_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      for (int i = 0; i < RDBUF_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_dat_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ram_burst_master.sv
// Burst master for a single-port RAM: write beats pass straight through, reads see 1-cycle RAM latency.
// Reads throttle to 2 beats buffered+in flight; RAM_BURST_MASTER_CHECKSUM_EN adds a per-burst XOR checksum port.
module ram_burst_master
  import ram_burst_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_write,
  input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
  input  logic [ADDRESS_WIDTH-1:0] cmd_len,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     ram_en,
  output logic                     ram_we,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0]    ram_din,
  input  logic [DATA_WIDTH-1:0]    ram_dout,
  output logic                     busy,
  output logic                     done
`ifdef RAM_BURST_MASTER_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0]    checksum
`endif
);

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [ADDRESS_WIDTH-1:0] left_q, left_d;
  logic                     inflight_q, inflight_d;
  logic                     done_q, done_d;

  logic                     buf_vld;
  logic [DATA_WIDTH-1:0]    buf_dat;
  logic [1:0]               buf_cnt;
  logic [1:0]               occupancy;
  logic                     accept;
  logic                     wr_beat;
  logic                     rd_issue;
  logic                     rd_pop;
  logic                     last_beat;

  // Outputs are gated with rst_n so they read as zero for the whole reset window.
  assign cmd_ready = rst_n && (state_q == ST_IDLE);
  assign wr_ready  = rst_n && (state_q == ST_WRITE);
  assign busy      = rst_n && (state_q != ST_IDLE);
  assign done      = rst_n && done_q;
  assign rd_valid  = rst_n && buf_vld;
  assign rd_data   = rst_n ? buf_dat : '0;

  assign occupancy = buf_cnt + {1'b0, inflight_q};
  assign accept    = cmd_valid && cmd_ready;
  assign wr_beat   = wr_ready && wr_valid;
  assign rd_issue  = rst_n && (state_q == ST_READ) && (occupancy < 2'(RDBUF_DEPTH));
  assign rd_pop    = rd_valid && rd_ready;
  assign last_beat = (left_q == '0);

  assign ram_en    = wr_beat || rd_issue;
  assign ram_we    = wr_beat;
  assign ram_addr  = ram_en ? addr_q : '0;
  assign ram_din   = wr_beat ? wr_data : '0;

  ram_burst_rdbuf #(
    .WIDTH(DATA_WIDTH)
  ) u_rdbuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_vld_i(inflight_q),
    .push_dat_i(ram_dout),
    .pop_rdy_i (rd_ready && rst_n),
    .pop_vld_o (buf_vld),
    .pop_dat_o (buf_dat),
    .count_o   (buf_cnt)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    left_d     = left_q;
    done_d     = 1'b0;
    inflight_d = rd_issue;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          addr_d  = cmd_addr;
          left_d  = cmd_len;
          state_d = cmd_write ? ST_WRITE : ST_READ;
        end
      end
      ST_WRITE: begin
        if (wr_beat) begin
          addr_d = addr_q + 1'b1;
          left_d = left_q - 1'b1;
          if (last_beat) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      ST_READ: begin
        if (rd_issue) begin
          addr_d = addr_q + 1'b1;
          left_d = left_q - 1'b1;
          if (last_beat) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Final beat leaves the buffer with nothing else outstanding.
        if (rd_pop && (buf_cnt == 2'd1) && !inflight_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      left_q     <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      left_q     <= left_d;
      inflight_q <= inflight_d;
      done_q     <= done_d;
    end
  end

`ifdef RAM_BURST_MASTER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] csum_q, csum_d;

  assign checksum = csum_q;

  always_comb begin
    acc_d  = acc_q;
    csum_d = csum_q;
    if (accept) begin
      acc_d  = '0;
      csum_d = '0;
    end
    if (wr_beat)    acc_d = acc_q ^ wr_data;
    if (inflight_q) acc_d = acc_q ^ ram_dout;
    if (done_d)     csum_d = acc_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q  <= '0;
      csum_q <= '0;
    end else begin
      acc_q  <= acc_d;
      csum_q <= csum_d;
    end
  end
`endif

endmodule

// File: tb/tb_ram_burst_master.sv
// Directed and random bursts against a behavioural RAM image; checks each beat, throttling, done and reset.
module tb_ram_burst_master;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [2:0] cmd_addr;
  logic [2:0] cmd_len;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [7:0] rd_data;
  logic       ram_en;
  logic       ram_we;
  logic [2:0] ram_addr;
  logic [7:0] ram_din;
  logic [7:0] ram_dout;
  logic       busy;
  logic       done;
`ifdef RAM_BURST_MASTER_CHECKSUM_EN
  logic [7:0] checksum;
`endif

  int checks   = 0;
  int failures = 0;

  logic [7:0] ram     [8];
  logic [7:0] ref_mem [8];
  logic [7:0] wdat    [8];
  logic [7:0] last_xor;

  ram_burst_master #(
    .DATA_WIDTH   (8),
    .ADDRESS_WIDTH(3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_len  (cmd_len),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_data  (wr_data),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .ram_en   (ram_en),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout),
    .busy     (busy),
    .done     (done)
`ifdef RAM_BURST_MASTER_CHECKSUM_EN
    ,
    .checksum (checksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port synchronous RAM, read data one cycle after the access.
  always @(posedge clk) begin
    if (ram_en && ram_we) ram[ram_addr] <= ram_din;
    if (ram_en && !ram_we) ram_dout <= ram[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_ram_en"}, ram_en, 0);
    check({tag, "_ram_we"}, ram_we, 0);
    check({tag, "_ram_addr"}, ram_addr, 0);
    check({tag, "_ram_din"}, ram_din, 0);
    check({tag, "_wr_ready"}, wr_ready, 0);
    check({tag, "_rd_valid"}, rd_valid, 0);
    check({tag, "_rd_data"}, rd_data, 0);
  endtask

  task automatic wait_idle();
    int c = 0;
    while (!cmd_ready && c < 50) begin
      @(negedge clk);
      #1;
      c++;
    end
    check("idle_wait", cmd_ready, 1);
  endtask

  task automatic send_cmd(input logic wr, input logic [2:0] a, input logic [2:0] len);
    wait_idle();
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_len   = len;
    #1;
    check("cmd_ready", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_addr  = 3'(($urandom));
    cmd_len   = 3'(($urandom));
  endtask

  task automatic check_done(input string tag);
    @(negedge clk);
    wr_valid = 1'b0;
    #1;
    check({tag, "_done"}, done, 1);
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_idle"}, cmd_ready, 1);
`ifdef RAM_BURST_MASTER_CHECKSUM_EN
    check({tag, "_checksum"}, checksum, last_xor);
`endif
    @(negedge clk);
    #1;
    check({tag, "_done_once"}, done, 0);
  endtask

  // mode 0: wr_valid held high, 1: toggles 1,0,1,0, 2: random
  task automatic wr_burst(input logic [2:0] a, input logic [2:0] len, input int mode);
    int n = int'(len) + 1;
    int i = 0;
    int cyc = 0;
    logic wv;
    logic [2:0] ea;
    logic [7:0] x = 8'h00;
    send_cmd(1'b1, a, len);
    while (i < n && cyc < 200) begin
      if (cyc > 0) @(negedge clk);
      wv = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      wr_valid = wv;
      wr_data  = wv ? wdat[i] : 8'($urandom);
      #1;
`ifdef RAM_BURST_MASTER_CHECKSUM_EN
      if (cyc == 0) check("wr_csum_clear", checksum, 0);
`endif
      check("wr_busy", busy, 1);
      check("wr_ready", wr_ready, 1);
      check("wr_done_early", done, 0);
      if (wv) begin
        ea = a + 3'(i);
        check("wr_en", ram_en, 1);
        check("wr_we", ram_we, 1);
        check("wr_addr", ram_addr, ea);
        check("wr_din", ram_din, wdat[i]);
        ref_mem[ea] = wdat[i];
        x ^= wdat[i];
        i++;
      end else begin
        check("wr_idle_en", ram_en, 0);
      end
      cyc++;
    end
    check("wr_beats", i, n);
    last_xor = x;
    check_done("wr");
  endtask

  // mode 0: rd_ready high, 1: low for 5 cycles mid-burst, 2: random; abort_after>0 stops early
  task automatic rd_burst(input logic [2:0] a, input logic [2:0] len, input int mode,
                          input int abort_after);
    int n = int'(len) + 1;
    int issued = 0;
    int popped = 0;
    int cyc = 0;
    logic rr;
    logic [7:0] x = 8'h00;
    send_cmd(1'b0, a, len);
    while (popped < n && cyc < 300 && !(abort_after > 0 && popped >= abort_after)) begin
      if (cyc > 0) @(negedge clk);
      rr = (mode == 0) ? 1'b1 : (mode == 1) ? !(cyc >= 3 && cyc < 8)
                                            : ($urandom_range(0, 3) != 0);
      rd_ready = rr;
      #1;
      check("rd_busy", busy, 1);
      check("rd_we", ram_we, 0);
      check("rd_wr_ready", wr_ready, 0);
      check("rd_done_early", done, 0);
      if (ram_en) begin
        check("rd_outstanding", (issued - popped) < 2, 1);
        check("rd_overissue", issued < n, 1);
        check("rd_addr", ram_addr, 3'(a + 3'(issued)));
        issued++;
      end
      if (rd_valid && rr) begin
        check("rd_data", rd_data, ref_mem[3'(a + 3'(popped))]);
        x ^= ref_mem[3'(a + 3'(popped))];
        popped++;
      end
      cyc++;
    end
    if (abort_after > 0) begin
      check("rd_abort_point", popped, abort_after);
    end else begin
      check("rd_beats", popped, n);
      last_xor = x;
      check_done("rd");
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 3'd0;
    cmd_len   = 3'd0;
    wr_valid  = 1'b0;
    wr_data   = 8'h00;
    rd_ready  = 1'b0;
    ram_dout  = 8'h00;
    last_xor  = 8'h00;
    for (int k = 0; k < 8; k++) ref_mem[k] = 8'hxx;

    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
`ifdef RAM_BURST_MASTER_CHECKSUM_EN
    check("reset_checksum", checksum, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("post_reset_cmd_ready", cmd_ready, 1);
    check("post_reset_busy", busy, 0);

    // Write burst 0x11..0x44 at address 2
    wdat[0] = 8'h11; wdat[1] = 8'h22; wdat[2] = 8'h33; wdat[3] = 8'h44;
    wr_burst(3'd2, 3'd3, 0);

    // Preload mem[n] = n, then a wrapping read
    for (int k = 0; k < 8; k++) wdat[k] = 8'(k);
    wr_burst(3'd0, 3'd7, 0);
    rd_burst(3'd6, 3'd3, 0, 0);

    // Eight-beat read with a 5-cycle rd_ready stall
    rd_burst(3'd0, 3'd7, 1, 0);

    // Write stream toggling 1,0,1,0
    for (int k = 0; k < 8; k++) wdat[k] = 8'($urandom);
    wr_burst(3'd5, 3'd3, 1);

    // Checksum pattern
    wdat[0] = 8'h0F; wdat[1] = 8'hF0; wdat[2] = 8'h55;
    wr_burst(3'd1, 3'd2, 0);
`ifdef RAM_BURST_MASTER_CHECKSUM_EN
    check("checksum_0xAA", last_xor, 8'hAA);
`endif

    // Reset in the middle of a read after two beats
    rd_burst(3'd3, 3'd7, 0, 2);
    @(negedge clk);
    rst_n    = 1'b0;
    rd_ready = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    #1;
    check_all_zero("midreset_held");
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check("after_abort_done", done, 0);
      check("after_abort_idle", cmd_ready, 1);
      check("after_abort_rd_valid", rd_valid, 0);
    end
    rd_burst(3'd0, 3'd7, 2, 0);

    // Random mix of bursts
    for (int b = 0; b < 24; b++) begin
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < 8; k++) wdat[k] = 8'($urandom);
        wr_burst(3'($urandom), 3'($urandom), 2);
      end else begin
        rd_burst(3'($urandom), 3'($urandom), 2, 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_burst_master.md
RAM_BURST_MASTER -- requirements
Module: ram_burst_master

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the RAM data width and the stream data width.
REQ-002 Parameter ADDRESS_WIDTH, default 3, SHALL set the RAM address width; depth is 2**ADDRESS_WIDTH.
REQ-003 clk  input  1  SHALL be the single clock; all logic samples on posedge clk.
REQ-004 rst_n  input  1  SHALL be the synchronous, active-low reset.
REQ-005 cmd_valid/cmd_ready  in/out  1/1  SHALL form the burst command handshake; transfer occurs when both are high.
REQ-006 cmd_write  input  1  SHALL select burst direction: 1 = write, 0 = read.
REQ-007 cmd_addr  input  ADDRESS_WIDTH  SHALL give the start address.
REQ-008 cmd_len  input  ADDRESS_WIDTH  SHALL give the beat count minus one, covering 1..2**ADDRESS_WIDTH beats.
REQ-009 wr_valid/wr_ready/wr_data  in/out/in  1/1/DATA_WIDTH  SHALL carry the write-data stream.
REQ-010 rd_valid/rd_ready/rd_data  out/in/out  1/1/DATA_WIDTH  SHALL carry the read-data stream.
REQ-011 ram_en, ram_we  output  1 each  SHALL drive the RAM port enable and write enable.
REQ-012 ram_addr  output  ADDRESS_WIDTH  SHALL drive the RAM port address.
REQ-013 ram_din  output  DATA_WIDTH  SHALL drive the RAM port write data.
REQ-014 ram_dout  input  DATA_WIDTH  SHALL be RAM read data, valid on the cycle after an en=1, we=0 access.
REQ-015 busy  output  1  SHALL be high from command acceptance until the burst completes.
REQ-016 done  output  1  SHALL pulse high for exactly one cycle when a burst completes.

Function
REQ-017 The FSM SHALL have four states: IDLE, WRITE, READ and DRAIN.
REQ-018 cmd_ready SHALL be high only in IDLE.
REQ-019 On acceptance, the block SHALL load the address and beat counters and go to WRITE if cmd_write=1, otherwise to READ.
REQ-020 In WRITE, wr_ready SHALL equal 1, and each wr handshake SHALL produce ram_en=1, ram_we=1, ram_din=wr_data and ram_addr=current address in that same cycle (combinational, zero latency).
REQ-021 In READ, the block SHALL issue ram_en=1, ram_we=0 only when buffered beats plus in-flight beats are fewer than 2.
REQ-022 Returned ram_dout SHALL be captured into a 2-entry read buffer one cycle after each issue, so no beat is ever dropped under rd_ready backpressure.
REQ-023 The address SHALL increment by one per issued beat and wrap modulo 2**ADDRESS_WIDTH (e.g., 7 wraps to 0 when ADDRESS_WIDTH=3).
REQ-024 After the last write beat, the block SHALL return to IDLE on the next cycle with done=1 for one cycle.
REQ-025 After the last read issue, the block SHALL enter DRAIN.
REQ-026 In DRAIN, done SHALL pulse in the cycle after the final rd handshake, with return to IDLE in that same cycle.
REQ-027 Outside an active access, ram_en and ram_we SHALL be 0.
REQ-028 Outside WRITE, wr_ready SHALL be 0.
REQ-029 rd_valid SHALL be high whenever the read buffer is non-empty, and rd_data SHALL be the oldest entry.
REQ-030 The block SHALL never issue a read and a write in the same cycle.

Reset
REQ-031 When rst_n=0 at a clock edge, the FSM SHALL go to IDLE and the counters SHALL clear.
REQ-032 Reset SHALL empty the read buffer, and any in-flight beat SHALL be discarded.
REQ-033 In reset, every output SHALL be 0: busy, done, ram_en, ram_we, ram_addr, ram_din, wr_ready, rd_valid and rd_data.
REQ-034 Because cmd_ready is IDLE-derived (REQ-018), cmd_ready SHALL be 1 from the first cycle after reset release.
REQ-035 Reset asserted mid-burst SHALL abort the burst without a done pulse, and RAM contents already written SHALL remain.

Configuration
REQ-036 With RAM_BURST_MASTER_CHECKSUM_EN defined, the block SHALL add output checksum[DATA_WIDTH-1:0]: the XOR of all beats of the most recent completed burst, updated in the done cycle.
REQ-037 checksum SHALL reset to 0 and SHALL clear at command acceptance.
REQ-038 Without RAM_BURST_MASTER_CHECKSUM_EN, the checksum port and its logic SHALL be absent.

Structure
REQ-039 Package ram_burst_pkg SHALL hold the FSM state enum and the read-buffer depth constant (2).
REQ-040 The read buffer SHALL be sub-module ram_burst_rdbuf, a 2-entry synchronous FIFO with valid/ready output.

Verification
REQ-041 Write burst: addr=2, len=3, data 0x11,0x22,0x33,0x44 with wr_valid held high -> ram_we on addresses 2,3,4,5 in 4 consecutive cycles, then done pulses once.
REQ-042 Wrapped read: RAM preloaded so mem[n]=n, then read addr=6, len=3, rd_ready=1 -> rd_data 6,7,0,1 in order, then done pulses.
REQ-043 Backpressure: 8-beat read with rd_ready low for 5 cycles mid-burst -> at most 2 buffered beats, no ram_en while the buffer is full, and all 8 beats delivered in order.
REQ-044 Reset during a read at beat 2 -> all outputs return to 0, no done pulse, and the next command is accepted normally.
REQ-045 Write-stream stalls: wr_valid toggling 1,0,1,0 -> ram_en only in cycles where wr_valid=1, with the address advancing only on those beats.
REQ-046 With RAM_BURST_MASTER_CHECKSUM_EN: write 0x0F,0xF0,0x55 -> checksum=0xAA at done.
